fp_align_controller: RTL and testbench
======================================

# fp_align_controller

Multi-cycle exponent-alignment sequencer for the floating-point adder front end. It accepts two operands (8-bit biased exponent plus 24-bit mantissa with hidden bit), compares the exponents, and routes the larger- and smaller-exponent mantissas through `mux_2x1_24bit` instances. It then shifts the smaller mantissa right one bit per cycle until the exponents match, producing aligned mantissas, a common exponent and a sticky bit for the downstream add/round stage.

## Interface
Parameters:
- `EXP_W`, default 8: exponent width.
- `MANT_W`, default 24: mantissa width including hidden bit. Only 24 is supported, to match `mux_2x1_24bit`.
- `MAX_SHIFT`, default 24: shift cap. After this many shifts the mantissa is all zero.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
  - `clk`  in  1  system clock, rising edge.
  - `reset`  in  1  synchronous, active-high; returns the block to IDLE.
- Control:
  - `start`  in  1  request; sampled only in IDLE.
  - `busy`  out  1  high in COMPARE and SHIFT.
  - `done`  out  1  one-cycle pulse in the DONE state.
- Operand inputs:
  - `exp_a`, `exp_b`  in  EXP_W  operand exponents.
  - `mant_a`, `mant_b`  in  MANT_W  operand mantissas.
- Results:
  - `exp_out`  out  EXP_W  larger exponent.
  - `mant_big`  out  MANT_W  mantissa of the larger-exponent operand, unshifted.
  - `mant_small`  out  MANT_W  aligned (right-shifted) mantissa of the other operand.
  - `sticky`  out  1  OR of every bit shifted out of `mant_small`.
  - `swap`  out  1  1 when operand B had the larger exponent.

## Operation
- States are IDLE, COMPARE, SHIFT and DONE.
- IDLE:
  - If `start`=1, register `exp_a`, `exp_b`, `mant_a` and `mant_b`, then go to COMPARE.
  - Otherwise stay in IDLE.
- COMPARE:
  - Set `swap` = (`exp_b` > `exp_a`). Equal exponents give `swap`=0.
  - The mux select is `swap`:
    - `mant_big` is loaded from mux(A,B,S=`swap`).
    - `mant_small` is loaded from mux(B,A,S=`swap`).
    - `exp_out` is loaded with the larger exponent.
  - Compute diff = |`exp_a` − `exp_b`| in EXP_W+1 bits, with no wrap.
  - Load the shift counter with min(diff, MAX_SHIFT) and clear `sticky`.
  - If the counter value is 0, go to DONE; otherwise go to SHIFT.
- SHIFT, once per cycle:
  - `sticky` <= `sticky` | `mant_small[0]`.
  - `mant_small` <= `mant_small` >> 1, zero-filled.
  - The counter decrements.
  - When the counter reaches 0 after the decrement, go to DONE.
- DONE: `done`=1 for one cycle, then go to IDLE.
- Result outputs hold their values in IDLE until the next accepted `start`.
- `start` while `busy` or in DONE is ignored, with no queuing.
- Inputs may change after the `start` cycle without affecting the result.
- Reset in any state:
  - Next state is IDLE.
  - All outputs are 0: `busy`, `done`, `swap`, `sticky`, `exp_out`, `mant_big`, `mant_small`.
  - An in-flight operation is discarded and no `done` is issued.

## Timing
- `start` is sampled at edge 0.
- COMPARE occupies cycle 1.
- SHIFT occupies cycles 2 .. 1+d, where d = min(diff, MAX_SHIFT).
- `done` is high in cycle 2+d.
- Total latency from `start` to `done` is 2+d cycles: minimum 2, maximum 26.
- `busy` is high for cycles 1 .. 1+d and low in DONE.
- The next `start` is accepted in cycle 3+d, the first IDLE cycle after DONE.
- All outputs are registered, with no combinational input-to-output paths.

## Structure
- Shared package `fp_pkg` holds:
  - constants `FP_EXP_W`=8, `FP_MANT_W`=24 and `FP_MAX_ALIGN`=24;
  - the state typedef `align_state_t` (IDLE, COMPARE, SHIFT, DONE).
- Sub-module: two instances of the existing `mux_2x1_24bit` (ports A, B, S, X), one for big-mantissa selection and one for small-mantissa selection.
- The FSM, counter and shift register stay in this module.

## Test plan
- Equal exponents: `exp_a`=`exp_b`=100, `mant_a`=0x800000, `mant_b`=0x900000 -> `done` 2 cycles after `start`; `swap`=0, `mant_big`=0x800000, `mant_small`=0x900000, `sticky`=0, `exp_out`=100.
- A larger: `exp_a`=130, `exp_b`=128, `mant_a`=0x800000, `mant_b`=0xC00001 -> `done` at cycle 4; `swap`=0, `mant_small`=0x300000, `sticky`=1, `exp_out`=130.
- B larger: `exp_a`=127, `exp_b`=129, `mant_a`=0x800003, `mant_b`=0xFFFFFF -> `swap`=1, `mant_big`=0xFFFFFF, `mant_small`=0x200000, `sticky`=1, `exp_out`=129.
- Cap: `exp_a`=200, `exp_b`=100, `mant_b`=0x800000 -> exactly 24 shifts, `done` at cycle 26, `mant_small`=0, `sticky`=1.
- Reset mid-SHIFT: using the cap case, assert `reset` at cycle 10 -> next cycle is IDLE, `busy`=0, all outputs 0, no `done` pulse.
- Busy `start`: pulse `start` at cycle 3 of the A-larger case with different operands -> first result is unchanged and no second `done` appears.
- Back-to-back: a new `start` in the first IDLE cycle after DONE -> accepted.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared definitions for the floating-point adder front end.
//   FP_EXP_W     : biased exponent width
//   FP_MANT_W    : mantissa width including the hidden bit
//   FP_MAX_ALIGN : largest useful alignment shift (mantissa fully shifted out)
//   align_state_t: sequencer states of fp_align_controller
package fp_pkg;

    localparam int unsigned FP_EXP_W     = 8;
    localparam int unsigned FP_MANT_W    = 24;
    localparam int unsigned FP_MAX_ALIGN = 24;

    typedef enum logic [1:0] {
        IDLE,
        COMPARE,
        SHIFT,
        DONE
    } align_state_t;

endpackage

// File: rtl/mux_2x1_24bit.sv
// Two-input 24-bit mantissa multiplexer.
//   A : selected when S = 0
//   B : selected when S = 1
//   S : select
//   X : selected operand
module mux_2x1_24bit (
    input  logic [23:0] A,
    input  logic [23:0] B,
    input  logic        S,
    output logic [23:0] X
);

    assign X = S ? B : A;

endmodule

// File: rtl/fp_align_controller.sv
// Multi-cycle exponent-alignment sequencer for the FP adder front end.
// Captures two operands on start, picks the larger-exponent operand, then
// shifts the other mantissa right one bit per cycle until the exponents match.
//   clk, reset          : clock, synchronous active-high reset
//   start               : request, sampled only in IDLE
//   busy                : high in COMPARE and SHIFT
//   done                : one-cycle pulse in DONE
//   exp_a/exp_b         : operand exponents
//   mant_a/mant_b       : operand mantissas (hidden bit included)
//   exp_out             : larger exponent
//   mant_big            : unshifted mantissa of the larger-exponent operand
//   mant_small          : aligned mantissa of the other operand
//   sticky              : OR of all bits shifted out of mant_small
//   swap                : operand B had the larger exponent
// MANT_W must stay 24 to match mux_2x1_24bit.
module fp_align_controller
    import fp_pkg::*;
#(
    parameter int unsigned EXP_W     = FP_EXP_W,
    parameter int unsigned MANT_W    = FP_MANT_W,
    parameter int unsigned MAX_SHIFT = FP_MAX_ALIGN
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    input  logic [EXP_W-1:0]  exp_a,
    input  logic [EXP_W-1:0]  exp_b,
    input  logic [MANT_W-1:0] mant_a,
    input  logic [MANT_W-1:0] mant_b,
    output logic [EXP_W-1:0]  exp_out,
    output logic [MANT_W-1:0] mant_big,
    output logic [MANT_W-1:0] mant_small,
    output logic              sticky,
    output logic              swap
);

    localparam int unsigned CNT_W = $clog2(MAX_SHIFT + 1);

    align_state_t state, next_state;

    logic [EXP_W-1:0]  exp_a_r, exp_b_r;
    logic [MANT_W-1:0] mant_a_r, mant_b_r;
    logic [CNT_W-1:0]  cnt;

    logic              swap_c;
    logic [EXP_W:0]    diff;
    logic [CNT_W-1:0]  cnt_init;
    logic [MANT_W-1:0] big_sel, small_sel;

    // Compare logic works on the captured operands so the inputs are free
    // to change after the start cycle.
    always_comb begin
        swap_c   = exp_b_r > exp_a_r;
        diff     = swap_c ? ({1'b0, exp_b_r} - {1'b0, exp_a_r})
                          : ({1'b0, exp_a_r} - {1'b0, exp_b_r});
        cnt_init = CNT_W'(diff);
        if (diff > (EXP_W + 1)'(MAX_SHIFT)) begin
            cnt_init = CNT_W'(MAX_SHIFT);
        end
    end

    mux_2x1_24bit u_mux_big (
        .A (mant_a_r),
        .B (mant_b_r),
        .S (swap_c),
        .X (big_sel)
    );

    mux_2x1_24bit u_mux_small (
        .A (mant_b_r),
        .B (mant_a_r),
        .S (swap_c),
        .X (small_sel)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = COMPARE;
                end
            end
            COMPARE: begin
                busy = 1'b1;
                if (cnt_init == '0) begin
                    next_state = DONE;
                end else begin
                    next_state = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                // Last shift: the counter reaches zero on this edge.
                if (cnt == CNT_W'(1)) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            exp_a_r    <= '0;
            exp_b_r    <= '0;
            mant_a_r   <= '0;
            mant_b_r   <= '0;
            cnt        <= '0;
            swap       <= 1'b0;
            sticky     <= 1'b0;
            exp_out    <= '0;
            mant_big   <= '0;
            mant_small <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        exp_a_r  <= exp_a;
                        exp_b_r  <= exp_b;
                        mant_a_r <= mant_a;
                        mant_b_r <= mant_b;
                    end
                end
                COMPARE: begin
                    swap       <= swap_c;
                    exp_out    <= swap_c ? exp_b_r : exp_a_r;
                    mant_big   <= big_sel;
                    mant_small <= small_sel;
                    cnt        <= cnt_init;
                    sticky     <= 1'b0;
                end
                SHIFT: begin
                    sticky     <= sticky | mant_small[0];
                    mant_small <= mant_small >> 1;
                    cnt        <= cnt - CNT_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_align_controller.sv
module tb_fp_align_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        busy, done;
    logic [7:0]  exp_a, exp_b;
    logic [23:0] mant_a, mant_b;
    logic [7:0]  exp_out;
    logic [23:0] mant_big, mant_small;
    logic        sticky, swap;

    fp_align_controller #(
        .EXP_W     (8),
        .MANT_W    (24),
        .MAX_SHIFT (24)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .exp_a      (exp_a),
        .exp_b      (exp_b),
        .mant_a     (mant_a),
        .mant_b     (mant_b),
        .exp_out    (exp_out),
        .mant_big   (mant_big),
        .mant_small (mant_small),
        .sticky     (sticky),
        .swap       (swap)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int    swap;
        int    exp_out;
        int    mant_big;
        int    mant_small;
        int    sticky;
        int    done_cyc;
        string tag;
    } exp_t;

    exp_t q[$];
    int checks   = 0;
    int failures = 0;
    int free_at  = 0;   // first edge number at which a start can be accepted

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Reference: alignment computed directly with integer arithmetic.
    function automatic exp_t model(input int ea, input int eb, input int ma, input int mb,
                                   input int s, input string tag);
        exp_t e;
        int   diff, d, sm;
        e.swap     = (eb > ea) ? 1 : 0;
        diff       = e.swap ? (eb - ea) : (ea - eb);
        d          = (diff > 24) ? 24 : diff;
        e.exp_out  = e.swap ? eb : ea;
        e.mant_big = e.swap ? mb : ma;
        sm         = e.swap ? ma : mb;
        e.mant_small = sm >> d;
        e.sticky   = ((sm & ((1 << d) - 1)) != 0) ? 1 : 0;
        e.done_cyc = s + 1 + d;
        e.tag      = tag;
        return e;
    endfunction

    // Present a start; the model decides whether the DUT is idle at the sampling edge.
    task automatic issue(input int ea, input int eb, input int ma, input int mb, input string tag);
        exp_t e;
        int   s;
        exp_a  = 8'(ea);
        exp_b  = 8'(eb);
        mant_a = 24'(ma);
        mant_b = 24'(mb);
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        exp_a  = 8'($urandom);
        exp_b  = 8'($urandom);
        mant_a = 24'($urandom);
        mant_b = 24'($urandom);
        s = cyc;
        if (s >= free_at) begin
            e = model(ea, eb, ma, mb, s, tag);
            q.push_back(e);
            free_at = e.done_cyc + 2;
            chk({tag, ".busy_compare"}, 64'(busy), 64'(1));
        end
    endtask

    task automatic wait_idle();
        @(negedge clk);
        while (cyc < free_at - 1) @(negedge clk);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".busy"},       64'(busy),       64'(0));
        chk({tag, ".done"},       64'(done),       64'(0));
        chk({tag, ".swap"},       64'(swap),       64'(0));
        chk({tag, ".sticky"},     64'(sticky),     64'(0));
        chk({tag, ".exp_out"},    64'(exp_out),    64'(0));
        chk({tag, ".mant_big"},   64'(mant_big),   64'(0));
        chk({tag, ".mant_small"}, 64'(mant_small), 64'(0));
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual=1 required=0 at cycle %0d", cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk({e.tag, ".done_cycle"}, 64'(cyc),        64'(e.done_cyc));
                chk({e.tag, ".swap"},       64'(swap),       64'(e.swap));
                chk({e.tag, ".exp_out"},    64'(exp_out),    64'(e.exp_out));
                chk({e.tag, ".mant_big"},   64'(mant_big),   64'(e.mant_big));
                chk({e.tag, ".mant_small"}, 64'(mant_small), 64'(e.mant_small));
                chk({e.tag, ".sticky"},     64'(sticky),     64'(e.sticky));
                chk({e.tag, ".busy_done"},  64'(busy),       64'(0));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s0, ea, eb, ma, mb;
        reset  = 1'b1;
        start  = 1'b0;
        exp_a  = '0;
        exp_b  = '0;
        mant_a = '0;
        mant_b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        reset = 1'b0;

        // Directed cases
        wait_idle();
        issue(100, 100, 24'h800000, 24'h900000, "equal");
        wait_idle();
        issue(130, 128, 24'h800000, 24'hC00001, "a_big");
        s0 = cyc;
        while (cyc < s0 + 2) @(negedge clk);
        issue(5, 250, 24'h123456, 24'h654321, "busy_start");
        wait_idle();
        issue(127, 129, 24'h800003, 24'hFFFFFF, "b_big");
        wait_idle();
        issue(200, 100, 24'hA5A5A5, 24'h800000, "cap");
        wait_idle();
        issue(3, 0, 24'h000001, 24'h000007, "b2b_small");

        // Reset in the middle of a capped shift
        wait_idle();
        issue(200, 100, 24'hFFFFFF, 24'h800000, "cap_reset");
        s0 = cyc;
        while (cyc < s0 + 9) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        q.delete();
        free_at = cyc + 1;
        chk_zero("reset_mid_shift");
        reset = 1'b0;
        repeat (30) @(negedge clk);

        // Randomized traffic, including starts that land while busy or in DONE
        for (int i = 0; i < 80; i++) begin
            ea = int'($urandom_range(0, 255));
            case ($urandom_range(0, 3))
                0:       eb = ea;
                1, 2: begin
                    eb = ea + int'($urandom_range(0, 60)) - 30;
                    if (eb < 0) eb = 0;
                    if (eb > 255) eb = 255;
                end
                default: eb = int'($urandom_range(0, 255));
            endcase
            ma = int'($urandom_range(0, 24'hFFFFFF));
            mb = int'($urandom_range(0, 24'hFFFFFF));
            if ($urandom_range(0, 1) == 1) begin
                ma = ma | 24'h800000;
                mb = mb | 24'h800000;
            end
            if ($urandom_range(0, 4) == 0) begin
                repeat ($urandom_range(0, 8)) @(negedge clk);
            end else begin
                wait_idle();
            end
            issue(ea, eb, ma, mb, $sformatf("rnd%0d", i));
        end

        wait_idle();
        repeat (10) @(negedge clk);
        chk("queue_drained", 64'(q.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
